// File: rtl/fifo_pack_reader.sv
// Read-side FIFO packer: pops PACK_FACTOR words per beat and streams a programmed number of wide beats.
// Optional stall/starve statistics outputs are compiled in with `define FIFO_PACK_STATS_EN.
module fifo_pack_reader #(
    parameter int DATA_WIDTH      = 8,
    parameter int PACK_FACTOR     = 4,
    parameter int LOG_PACK_FACTOR = 2,
    parameter int BEAT_CNT_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_WIDTH-1:0]             fifo_data_read,
    input  logic                              fifo_empty,
    output logic                              fifo_next_read,
    input  logic                              start,
    input  logic [BEAT_CNT_WIDTH-1:0]         num_beats,
    output logic                              busy,
    output logic                              done,
    output logic [DATA_WIDTH*PACK_FACTOR-1:0] out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_last
`ifdef FIFO_PACK_STATS_EN
    ,
    output logic [31:0]                       stall_cycles,
    output logic [31:0]                       starve_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        PACK,
        SEND
    } state_t;

    localparam logic [LOG_PACK_FACTOR-1:0] LAST_LANE = LOG_PACK_FACTOR'(PACK_FACTOR - 1);

    state_t                      state;
    state_t                      state_next;
    logic [LOG_PACK_FACTOR-1:0]  lane_cnt;
    logic [BEAT_CNT_WIDTH-1:0]   beats_left;

    logic pop;
    logic handshake;
    logic last_lane;
    logic start_accept;
    logic final_beat;

    assign pop          = (state == PACK) && !fifo_empty;
    assign handshake    = out_valid && out_ready;
    assign last_lane    = (lane_cnt == LAST_LANE);
    assign start_accept = (state == IDLE) && start;
    assign final_beat   = (beats_left == BEAT_CNT_WIDTH'(1));

    assign fifo_next_read = pop;
    assign busy           = (state != IDLE);
    assign out_last       = out_valid && final_beat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && (num_beats != '0)) begin
                    state_next = PACK;
                end
            end
            PACK: begin
                if (pop && last_lane) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (handshake) begin
                    state_next = final_beat ? IDLE : PACK;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Lane fill, beat presentation and job bookkeeping; out_valid only ever rises in PACK
    // and only ever falls on a handshake, so out_data is frozen for the whole of SEND.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_cnt   <= '0;
            beats_left <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start_accept) begin
                if (num_beats != '0) begin
                    beats_left <= num_beats;
                    lane_cnt   <= '0;
                end else begin
                    done <= 1'b1;
                end
            end
            if (pop) begin
                out_data[lane_cnt*DATA_WIDTH +: DATA_WIDTH] <= fifo_data_read;
                if (last_lane) begin
                    lane_cnt  <= '0;
                    out_valid <= 1'b1;
                end else begin
                    lane_cnt <= lane_cnt + 1'b1;
                end
            end
            if (handshake) begin
                out_valid  <= 1'b0;
                beats_left <= beats_left - 1'b1;
                if (final_beat) begin
                    done <= 1'b1;
                end
            end
        end
    end

`ifdef FIFO_PACK_STATS_EN
    // Saturating back-pressure and starvation counters, restarted with every accepted job.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles  <= '0;
            starve_cycles <= '0;
        end else if (start_accept) begin
            stall_cycles  <= '0;
            starve_cycles <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if ((state == PACK) && fifo_empty && (starve_cycles != 32'hFFFF_FFFF)) begin
                starve_cycles <= starve_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_pack_reader.sv
// Scoreboard bench for fifo_pack_reader: a queue-based FIFO model feeds the DUT and a
// negedge monitor compares every presented beat against beats predicted from the word stream.
module tb_fifo_pack_reader;

    localparam int DW  = 8;
    localparam int PF  = 4;
    localparam int LPF = 2;
    localparam int BCW = 16;
    localparam int BW  = DW * PF;

    logic           clk;
    logic           rst;
    logic [DW-1:0]  fifo_data_read;
    logic           fifo_empty;
    logic           fifo_next_read;
    logic           start;
    logic [BCW-1:0] num_beats;
    logic           busy;
    logic           done;
    logic [BW-1:0]  out_data;
    logic           out_valid;
    logic           out_ready;
    logic           out_last;
`ifdef FIFO_PACK_STATS_EN
    logic [31:0]    stall_cycles;
    logic [31:0]    starve_cycles;
`endif

    fifo_pack_reader #(
        .DATA_WIDTH(DW),
        .PACK_FACTOR(PF),
        .LOG_PACK_FACTOR(LPF),
        .BEAT_CNT_WIDTH(BCW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fifo_data_read(fifo_data_read),
        .fifo_empty(fifo_empty),
        .fifo_next_read(fifo_next_read),
        .start(start),
        .num_beats(num_beats),
        .busy(busy),
        .done(done),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last)
`ifdef FIFO_PACK_STATS_EN
        ,
        .stall_cycles(stall_cycles),
        .starve_cycles(starve_cycles)
`endif
    );

    typedef struct {
        logic [BW-1:0] data;
        logic          last;
    } beat_t;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] pending[$];
    beat_t         exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int valid_cycles = 0;
    int pops = 0;
    int feed_mode = 0;
    int ready_mode = 0;
    int empty_run = 0;
    int stall_run = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog expired (actual: still running, required: finished)");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every cycle a beat is presented it must match the head prediction.
    always @(negedge clk) begin
        if (rst) begin
            if (done) done_cnt++;
            if (out_valid) begin
                valid_cycles++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_beat", out_data, '0);
                    checkOutput("unexpected_beat_valid", 64'(out_valid), 64'(0));
                end else begin
                    checkOutput("beat_data", out_data, exp_q[0].data);
                    checkOutput("beat_last", 64'(out_last), 64'(exp_q[0].last));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic fifoRefresh();
        fifo_empty     = (fifo_q.size() == 0);
        fifo_data_read = fifo_empty ? '0 : fifo_q[0];
    endtask

    // One clock: choose out_ready, sample the pop request, advance the FIFO model, feed words.
    task automatic applyStimulus();
        logic pop;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: begin
                if (out_valid) begin
                    if (stall_run < 5) begin
                        out_ready = 1'b0;
                        stall_run++;
                    end else begin
                        out_ready = 1'b1;
                        stall_run = 0;
                    end
                end else begin
                    out_ready = 1'b1;
                end
            end
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
        #2;
        pop = fifo_next_read;
        @(posedge clk);
        #1;
        if (pop) begin
            checkOutput("no_pop_when_empty", 64'(fifo_q.size() != 0), 64'(1));
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            pops++;
        end
        case (feed_mode)
            1: if (pending.size() != 0 && $urandom_range(0, 1) == 1) fifo_q.push_back(pending.pop_front());
            2: begin
                if (fifo_q.size() == 0 && pending.size() != 0) begin
                    empty_run++;
                    if (empty_run > 6) begin
                        while (pending.size() != 0) fifo_q.push_back(pending.pop_front());
                        empty_run = 0;
                    end
                end
            end
            default: ;
        endcase
        fifoRefresh();
    endtask

    // Predict the beats of an n-beat job from the words the FIFO will deliver, in order.
    task automatic buildExpected(input int n);
        logic [DW-1:0] words[$];
        beat_t b;
        foreach (fifo_q[i]) words.push_back(fifo_q[i]);
        foreach (pending[i]) words.push_back(pending[i]);
        for (int k = 0; k < n; k++) begin
            b.data = '0;
            for (int l = 0; l < PF; l++) b.data[l*DW +: DW] = words[k*PF + l];
            b.last = (k == n - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic runJob(input int n, input int rmode, input int fmode, input bit restart);
        int done0;
        int pops0;
        int vc0;
        int cyc;
        buildExpected(n);
        ready_mode = rmode;
        feed_mode  = fmode;
        empty_run  = 0;
        stall_run  = 0;
        done0 = done_cnt;
        pops0 = pops;
        vc0   = valid_cycles;
        num_beats = BCW'(n);
        start = 1'b1;
        applyStimulus();
        start = 1'b0;
        num_beats = BCW'($urandom);
        cyc = 0;
        while (done_cnt == done0 && cyc < 3000) begin
            if (restart && cyc == 3) begin
                start = 1'b1;
                num_beats = BCW'(7);
            end else begin
                start = 1'b0;
            end
            applyStimulus();
            cyc++;
        end
        start = 1'b0;
        checkOutput("job_finished_in_budget", 64'(cyc < 3000), 64'(1));
        applyStimulus();
        applyStimulus();
        checkOutput("done_pulses", 64'(done_cnt - done0), 64'(1));
        checkOutput("pop_count", 64'(pops - pops0), 64'(n * PF));
        checkOutput("beats_all_accepted", 64'(exp_q.size()), 64'(0));
        checkOutput("busy_after_job", 64'(busy), 64'(0));
        if (n == 0) checkOutput("no_valid_for_empty_job", 64'(valid_cycles - vc0), 64'(0));
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        num_beats = '0;
        out_ready = 1'b0;
        fifoRefresh();
        #3;
        checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_done", 64'(done), 64'(0));
        checkOutput("reset_out_data", out_data, '0);
        checkOutput("reset_next_read", 64'(fifo_next_read), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single beat from a preloaded FIFO.
        fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        fifoRefresh();
        runJob(1, 0, 0, 1'b0);
`ifdef FIFO_PACK_STATS_EN
        checkOutput("starve_single", starve_cycles, 64'(0));
`endif

        // Three beats with five stall cycles per beat.
        for (int i = 0; i < 12; i++) fifo_q.push_back(DW'(i));
        fifoRefresh();
        runJob(3, 1, 0, 1'b0);
`ifdef FIFO_PACK_STATS_EN
        checkOutput("stall_cycles", stall_cycles, 64'(15));
`endif

        // FIFO runs dry after two words; the rest arrives after six empty cycles.
        fifo_q  = '{8'hA1, 8'hB2};
        pending = '{8'hC3, 8'hD4};
        fifoRefresh();
        runJob(1, 0, 2, 1'b0);
`ifdef FIFO_PACK_STATS_EN
        checkOutput("starve_cycles", starve_cycles, 64'(6));
`endif

        // Zero-beat job: nothing popped, immediate done.
        fifo_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        fifoRefresh();
        runJob(0, 0, 0, 1'b0);
        checkOutput("zero_job_fifo_untouched", 64'(fifo_q.size()), 64'(4));
        fifo_q.delete();
        fifoRefresh();

        // Reset while a beat is being presented.
        fifo_q = '{8'h55, 8'h66, 8'h77, 8'h88};
        fifoRefresh();
        buildExpected(1);
        ready_mode = 3;
        feed_mode  = 0;
        num_beats  = BCW'(1);
        start = 1'b1;
        applyStimulus();
        start = 1'b0;
        for (int c = 0; c < 50 && !out_valid; c++) applyStimulus();
        checkOutput("send_reached_before_reset", 64'(out_valid), 64'(1));
        rst = 1'b0;
        #1;
        checkOutput("async_reset_out_valid", 64'(out_valid), 64'(0));
        checkOutput("async_reset_busy", 64'(busy), 64'(0));
        checkOutput("async_reset_done", 64'(done), 64'(0));
        checkOutput("async_reset_out_data", out_data, '0);
        exp_q.delete();
        fifo_q.delete();
        pending.delete();
        fifoRefresh();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        fifoRefresh();
        runJob(1, 0, 0, 1'b0);

        // A second start while busy must not change the beat count.
        for (int i = 0; i < 12; i++) fifo_q.push_back(DW'(8'h80 + i));
        fifoRefresh();
        runJob(2, 0, 0, 1'b1);
        checkOutput("ignored_start_words_left", 64'(fifo_q.size()), 64'(4));
        fifo_q.delete();
        fifoRefresh();

        // Randomised jobs with random back-pressure and trickling FIFO input.
        for (int j = 0; j < 8; j++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int w = 0; w < n * PF; w++) pending.push_back(DW'($urandom));
            runJob(n, 2, 1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_pack_reader.md
Name: fifo_pack_reader

Overview:
- Read-side companion to the team's FIFO.
- Drains the FIFO's combinational head through its data_read, empty and next_read interface.
- Packs PACK_FACTOR consecutive DATA_WIDTH words into one wide beat.
- Emits each beat on a valid/ready output stream, for a programmed number of beats per job.
- Placed between activation/weight FIFOs and wide datapath consumers in the accelerator pipeline.

Parameters:
DATA_WIDTH, 8, width of one FIFO word
PACK_FACTOR, 4, FIFO words per output beat (>=2)
LOG_PACK_FACTOR, 2, bits of lane counter (ceil log2 PACK_FACTOR)
BEAT_CNT_WIDTH, 16, width of beat counter and num_beats

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low
fifo_data_read  in  DATA_WIDTH  FIFO head word (combinational)
fifo_empty  in  1  FIFO empty flag
fifo_next_read  out  1  pop FIFO head this cycle
start  in  1  one-cycle job start request
num_beats  in  BEAT_CNT_WIDTH  output beats for job, sampled on accepted start
busy  out  1  job in progress
done  out  1  one-cycle pulse at job end
out_data  out  DATA_WIDTH*PACK_FACTOR  packed beat, lane 0 in LSBs
out_valid  out  1  beat available
out_ready  in  1  consumer accepts beat
out_last  out  1  current beat is final beat of job

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; lane_cnt=0; beats_left=0; out_data=0; out_valid=0; done=0; busy=0. Reset mid-job aborts the job immediately. No done pulse is produced for the aborted job.
- FSM states: IDLE, PACK, SEND.
- IDLE:
  - busy=0.
  - start=1 with num_beats!=0: latch beats_left=num_beats, lane_cnt=0, next state PACK.
  - start=1 with num_beats==0: done=1 next cycle, stay IDLE.
- PACK:
  - busy=1.
  - fifo_next_read = ~fifo_empty, combinational, asserted only in PACK.
  - On each pop: out_data lane[lane_cnt] <= fifo_data_read, lane_cnt += 1.
  - Pop with lane_cnt==PACK_FACTOR-1: lane_cnt <= 0, out_valid <= 1, next state SEND.
  - fifo_empty=1: stall in PACK, no pop, partial lanes retained.
- SEND:
  - busy=1. fifo_next_read=0.
  - out_valid=1, with out_data and out_last held stable until handshake.
  - Handshake = out_valid & out_ready; on it: out_valid <= 0, beats_left -= 1.
  - After handshake: if beats_left was 1, next state IDLE with done=1 for one cycle; otherwise next state PACK.
- out_last = out_valid & (beats_left==1).
- start while busy=1: ignored, num_beats not sampled.
- Latency: first FIFO pop occurs the cycle after start (PACK entered). out_valid rises the cycle after the PACK_FACTOR-th pop. Peak throughput is one beat per PACK_FACTOR+1 cycles (no pop/send overlap).
- Width rules:
  - beats_left decrements only on handshake, never wraps below 0.
  - lane_cnt wraps to 0 only after the final lane.
  - No FIFO pop ever occurs while fifo_empty=1.
- Unused lanes never exist: every beat contains exactly PACK_FACTOR fresh words.

Optional Feature:
- Macro: FIFO_PACK_STATS_EN.
- Defined:
  - Adds outputs stall_cycles[31:0] and starve_cycles[31:0].
  - stall_cycles increments each cycle with out_valid & ~out_ready.
  - starve_cycles increments each cycle in PACK with fifo_empty=1.
  - Both counters clear on reset and on accepted start, and saturate at 0xFFFFFFFF.
- Undefined: the ports and counters do not exist; functional behaviour is otherwise identical.

Test Plan:
- FIFO preloaded with 0x11,0x22,0x33,0x44, start with num_beats=1, out_ready=1 -> exactly 4 pops; out_data=0x44332211 with out_valid=1 and out_last=1 for one cycle; done pulse the following cycle; busy=0.
- num_beats=3, 12 words 0x00..0x0B, out_ready held 0 for 5 cycles at each beat -> beats 0x03020100, 0x07060504, 0x0B0A0908 each held stable while stalled; out_last only on the third beat; stall_cycles=15 with FIFO_PACK_STATS_EN.
- FIFO empty after 2 words of a beat, then 2 more words arrive 6 cycles later -> no pops while empty; beat correct; starve_cycles=6 with macro.
- start with num_beats=0 -> no pops, out_valid never asserted, done=1 for one cycle.
- Reset asserted during SEND with out_valid=1 -> out_valid, busy, done and out_data go 0 asynchronously, before the next clock edge; new start with num_beats=1 after release behaves as in the first scenario.
- start pulsed again while busy with num_beats=7 -> ignored; job completes with the original beat count.
